// File: rtl/parking_lane_counter.sv
// parking_lane_counter
// Per-lane beam-pair direction detectors (outer sensor a, inner sensor b)
// merged into one saturating occupancy count with full/empty decode and
// sticky overflow/underflow flags.
// Optional macro: PARKING_INPUT_SYNC_EN inserts a 2-flop synchronizer on
// every a/b bit, adding two cycles of input latency.
module parking_lane_counter #(
  parameter int LANES    = 2,
  parameter int CAPACITY = 15,
  parameter int CNT_W    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [LANES-1:0] a_i,
  input  logic [LANES-1:0] b_i,
  output logic [LANES-1:0] enter_o,
  output logic [LANES-1:0] leave_o,
  output logic [LANES-1:0] seq_err_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             ovf_o,
  output logic             unf_o
);

  // Lane states: E* walk the entry path, X* the mirrored exit path.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    E1   = 3'd1,
    E2   = 3'd2,
    E3   = 3'd3,
    X1   = 3'd4,
    X2   = 3'd5,
    X3   = 3'd6,
    BAD  = 3'd7
  } laneState_t;

  localparam logic signed [CNT_W+3:0] CAP_S = (CNT_W+4)'(CAPACITY);

  logic [LANES-1:0] laneA;
  logic [LANES-1:0] laneB;

  // Combinational "fires this edge" flags, shared with the occupancy counter
  // so the count moves on the same edge as the registered pulses.
  logic [LANES-1:0] laneEnter_d;
  logic [LANES-1:0] laneLeave_d;

`ifdef PARKING_INPUT_SYNC_EN
  logic [LANES-1:0] syncA1_q;
  logic [LANES-1:0] syncA2_q;
  logic [LANES-1:0] syncB1_q;
  logic [LANES-1:0] syncB2_q;

  // Two-stage synchronizer on every sensor bit before it reaches the FSMs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      syncA1_q <= '0;
      syncA2_q <= '0;
      syncB1_q <= '0;
      syncB2_q <= '0;
    end else begin
      syncA1_q <= a_i;
      syncA2_q <= syncA1_q;
      syncB1_q <= b_i;
      syncB2_q <= syncB1_q;
    end
  end

  assign laneA = syncA2_q;
  assign laneB = syncB2_q;
`else
  assign laneA = a_i;
  assign laneB = b_i;
`endif

  for (genvar g = 0; g < LANES; g++) begin : gLane
    laneState_t state_q;
    laneState_t state_d;
    logic       enter_q;
    logic       leave_q;
    logic       err_q;
    logic       fireEnter;
    logic       fireLeave;
    logic       fireErr;
    logic [1:0] ab;

    assign ab = {laneA[g], laneB[g]};

    // Next-state and firing decode; an input equal to the state's own
    // pattern falls through to the default and holds the state.
    always_comb begin
      state_d   = state_q;
      fireEnter = 1'b0;
      fireLeave = 1'b0;
      fireErr   = 1'b0;
      case (state_q)
        IDLE: begin
          if (ab == 2'b10)      state_d = E1;
          else if (ab == 2'b01) state_d = X1;
          else if (ab == 2'b11) begin state_d = BAD; fireErr = 1'b1; end
        end
        E1: begin
          if (ab == 2'b11)      state_d = E2;
          else if (ab == 2'b00) state_d = IDLE;
          else if (ab == 2'b01) begin state_d = BAD; fireErr = 1'b1; end
        end
        E2: begin
          if (ab == 2'b01)      state_d = E3;
          else if (ab == 2'b10) state_d = E1;
          else if (ab == 2'b00) begin state_d = BAD; fireErr = 1'b1; end
        end
        E3: begin
          if (ab == 2'b00)      begin state_d = IDLE; fireEnter = 1'b1; end
          else if (ab == 2'b11) state_d = E2;
          else if (ab == 2'b10) begin state_d = BAD; fireErr = 1'b1; end
        end
        X1: begin
          if (ab == 2'b11)      state_d = X2;
          else if (ab == 2'b00) state_d = IDLE;
          else if (ab == 2'b10) begin state_d = BAD; fireErr = 1'b1; end
        end
        X2: begin
          if (ab == 2'b10)      state_d = X3;
          else if (ab == 2'b01) state_d = X1;
          else if (ab == 2'b00) begin state_d = BAD; fireErr = 1'b1; end
        end
        X3: begin
          if (ab == 2'b00)      begin state_d = IDLE; fireLeave = 1'b1; end
          else if (ab == 2'b11) state_d = X2;
          else if (ab == 2'b01) begin state_d = BAD; fireErr = 1'b1; end
        end
        BAD: begin
          if (ab == 2'b00) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Lane state and its one-cycle pulses, registered together.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= IDLE;
        enter_q <= 1'b0;
        leave_q <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        enter_q <= fireEnter;
        leave_q <= fireLeave;
        err_q   <= fireErr;
      end
    end

    assign laneEnter_d[g] = fireEnter;
    assign laneLeave_d[g] = fireLeave;
    assign enter_o[g]     = enter_q;
    assign leave_o[g]     = leave_q;
    assign seq_err_o[g]   = err_q;
  end

  logic [CNT_W-1:0]        count_q;
  logic [CNT_W-1:0]        count_d;
  logic                    ovf_q;
  logic                    ovf_d;
  logic                    unf_q;
  logic                    unf_d;
  logic signed [CNT_W+3:0] upSum;
  logic signed [CNT_W+3:0] downSum;
  logic signed [CNT_W+3:0] nextCount;

  // Net occupancy change with saturation; opposing events cancel before
  // clamping so they never raise a flag.
  always_comb begin
    upSum   = '0;
    downSum = '0;
    for (int i = 0; i < LANES; i++) begin
      upSum   = upSum + (CNT_W+4)'(laneEnter_d[i]);
      downSum = downSum + (CNT_W+4)'(laneLeave_d[i]);
    end
    nextCount = $signed({4'b0000, count_q}) + upSum - downSum;
    count_d   = nextCount[CNT_W-1:0];
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    if (nextCount > CAP_S) begin
      count_d = CAP_S[CNT_W-1:0];
      ovf_d   = 1'b1;
    end else if (nextCount[CNT_W+3]) begin
      count_d = '0;
      unf_d   = 1'b1;
    end
  end

  // Occupancy register and sticky saturation flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count_o = count_q;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;
  assign full_o  = (count_q == CAP_S[CNT_W-1:0]);
  assign empty_o = (count_q == '0);

endmodule

// File: tb/tb_parking_lane_counter.sv
// tb_parking_lane_counter
// Drives two instances (capacity 15 and capacity 3) from the same sensors
// and compares every output each cycle with a reference model that treats
// the sensor pair as a position on the Gray ring 00-10-11-01: single-bit
// moves step a progress counter, +4 is an entry, -4 an exit, and a
// two-bit jump is an error that waits for 00.
// Honours PARKING_INPUT_SYNC_EN by delaying the model's view of the inputs.
module tb_parking_lane_counter;

  localparam int LANES = 2;
  localparam int CAP_A = 15;
  localparam int CNT_A = 4;
  localparam int CAP_B = 3;
  localparam int CNT_B = 2;

  logic             clock;
  logic             reset;
  logic [LANES-1:0] a;
  logic [LANES-1:0] b;

  logic [LANES-1:0] dutEnterA, dutLeaveA, dutErrA;
  logic [CNT_A-1:0] dutCountA;
  logic             dutFullA, dutEmptyA, dutOvfA, dutUnfA;
  logic [LANES-1:0] dutEnterB, dutLeaveB, dutErrB;
  logic [CNT_B-1:0] dutCountB;
  logic             dutFullB, dutEmptyB, dutOvfB, dutUnfB;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int               prog [LANES];
  bit               bad [LANES];
  logic [LANES-1:0] expEnter, expLeave, expErr;
  int               cntA, cntB;
  bit               ovfFlagA, unfFlagA, ovfFlagB, unfFlagB;
`ifdef PARKING_INPUT_SYNC_EN
  logic [LANES-1:0] shA [2];
  logic [LANES-1:0] shB [2];
`endif

  // Random-walk generator state.
  int         genPos [LANES];
  logic [1:0] ringPat [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  parking_lane_counter #(.LANES(LANES), .CAPACITY(CAP_A), .CNT_W(CNT_A)) dutA (
    .clk_i(clock), .rst_i(reset), .a_i(a), .b_i(b),
    .enter_o(dutEnterA), .leave_o(dutLeaveA), .seq_err_o(dutErrA),
    .count_o(dutCountA), .full_o(dutFullA), .empty_o(dutEmptyA),
    .ovf_o(dutOvfA), .unf_o(dutUnfA)
  );

  parking_lane_counter #(.LANES(LANES), .CAPACITY(CAP_B), .CNT_W(CNT_B)) dutB (
    .clk_i(clock), .rst_i(reset), .a_i(a), .b_i(b),
    .enter_o(dutEnterB), .leave_o(dutLeaveB), .seq_err_o(dutErrB),
    .count_o(dutCountB), .full_o(dutFullB), .empty_o(dutEmptyB),
    .ovf_o(dutOvfB), .unf_o(dutUnfB)
  );

  // Free-running 10-unit clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Guard against a stalled run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int ringPos(input logic [1:0] pat);
    case (pat)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic modelReset();
    for (int l = 0; l < LANES; l++) begin
      prog[l] = 0;
      bad[l]  = 1'b0;
    end
    expEnter = '0;
    expLeave = '0;
    expErr   = '0;
    cntA = 0;
    cntB = 0;
    ovfFlagA = 1'b0;
    unfFlagA = 1'b0;
    ovfFlagB = 1'b0;
    unfFlagB = 1'b0;
`ifdef PARKING_INPUT_SYNC_EN
    shA[0] = '0; shA[1] = '0;
    shB[0] = '0; shB[1] = '0;
`endif
  endtask

  task automatic updateCount(inout int cnt, inout bit ovf, inout bit unf,
                             input int cap, input int delta);
    int nxt;
    nxt = cnt + delta;
    if (nxt > cap) begin
      cnt = cap;
      ovf = 1'b1;
    end else if (nxt < 0) begin
      cnt = 0;
      unf = 1'b1;
    end else begin
      cnt = nxt;
    end
  endtask

  task automatic modelEdge();
    logic [LANES-1:0] effA, effB;
    int delta;
`ifdef PARKING_INPUT_SYNC_EN
    effA = shA[1];
    effB = shB[1];
    shA[1] = shA[0];
    shB[1] = shB[0];
    shA[0] = a;
    shB[0] = b;
`else
    effA = a;
    effB = b;
`endif
    for (int l = 0; l < LANES; l++) begin
      logic [1:0] pat;
      int cur, step;
      pat = {effA[l], effB[l]};
      expEnter[l] = 1'b0;
      expLeave[l] = 1'b0;
      expErr[l]   = 1'b0;
      if (bad[l]) begin
        if (pat == 2'b00) bad[l] = 1'b0;
      end else begin
        cur  = ((prog[l] % 4) + 4) % 4;
        step = (ringPos(pat) - cur + 4) % 4;
        if (step == 1) prog[l] = prog[l] + 1;
        else if (step == 3) prog[l] = prog[l] - 1;
        else if (step == 2) begin
          bad[l]    = 1'b1;
          prog[l]   = 0;
          expErr[l] = 1'b1;
        end
        if (prog[l] == 4) begin
          expEnter[l] = 1'b1;
          prog[l] = 0;
        end else if (prog[l] == -4) begin
          expLeave[l] = 1'b1;
          prog[l] = 0;
        end
      end
    end
    delta = $countones(expEnter) - $countones(expLeave);
    updateCount(cntA, ovfFlagA, unfFlagA, CAP_A, delta);
    updateCount(cntB, ovfFlagB, unfFlagB, CAP_B, delta);
  endtask

  task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkField("enterA", 32'(dutEnterA), 32'(expEnter));
    checkField("leaveA", 32'(dutLeaveA), 32'(expLeave));
    checkField("seqErrA", 32'(dutErrA), 32'(expErr));
    checkField("countA", 32'(dutCountA), 32'(cntA));
    checkField("fullA", 32'(dutFullA), 32'(cntA == CAP_A));
    checkField("emptyA", 32'(dutEmptyA), 32'(cntA == 0));
    checkField("ovfA", 32'(dutOvfA), 32'(ovfFlagA));
    checkField("unfA", 32'(dutUnfA), 32'(unfFlagA));
    checkField("enterB", 32'(dutEnterB), 32'(expEnter));
    checkField("leaveB", 32'(dutLeaveB), 32'(expLeave));
    checkField("seqErrB", 32'(dutErrB), 32'(expErr));
    checkField("countB", 32'(dutCountB), 32'(cntB));
    checkField("fullB", 32'(dutFullB), 32'(cntB == CAP_B));
    checkField("emptyB", 32'(dutEmptyB), 32'(cntB == 0));
    checkField("ovfB", 32'(dutOvfB), 32'(ovfFlagB));
    checkField("unfB", 32'(dutUnfB), 32'(unfFlagB));
  endtask

  // One clock of stimulus: lane patterns are {a,b}.
  task automatic applyStimulus(input logic [1:0] ab0, input logic [1:0] ab1);
    a = {ab1[1], ab0[1]};
    b = {ab1[0], ab0[0]};
    @(posedge clock);
    modelEdge();
    #1;
    checkOutput();
  endtask

  // Asynchronous reset asserted between edges, held over one edge.
  task automatic doReset();
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput();
    @(posedge clock);
    #1;
    checkOutput();
    #2;
    reset = 1'b0;
  endtask

  // Plays up to 8 patterns (listed from the MSB) on both lanes.
  task automatic playBoth(input logic [15:0] seq0, input logic [15:0] seq1, input int len);
    for (int i = 0; i < len; i++) begin
      applyStimulus(seq0[15-2*i -: 2], seq1[15-2*i -: 2]);
    end
  endtask

  task automatic playSeq(input int lane, input logic [15:0] seq, input int len);
    if (lane == 0) playBoth(seq, 16'h0000, len);
    else playBoth(16'h0000, seq, len);
  endtask

  task automatic settle();
    applyStimulus(2'b00, 2'b00);
    applyStimulus(2'b00, 2'b00);
  endtask

  task automatic randomPhase(input int cycles, input int bias0, input int bias1);
    for (int c = 0; c < cycles; c++) begin
      for (int l = 0; l < LANES; l++) begin
        int r, bias;
        r    = int'($urandom_range(0, 19));
        bias = (l == 0) ? bias0 : bias1;
        if (r == 0) genPos[l] = (genPos[l] + 2) % 4;
        else if (r >= 6 && r < 16) genPos[l] = (genPos[l] + bias + 4) % 4;
        else if (r >= 16) genPos[l] = (genPos[l] - bias + 4) % 4;
      end
      applyStimulus(ringPat[genPos[0]], ringPat[genPos[1]]);
    end
  endtask

  localparam logic [15:0] ENTRY    = {2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 6'b0};
  localparam logic [15:0] EXIT     = {2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 6'b0};
  localparam logic [15:0] ABORT    = {2'b10, 2'b11, 2'b10, 2'b00, 8'b0};
  localparam logic [15:0] REVERSAL = {2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b00, 4'b0};
  localparam logic [15:0] JUMP     = {2'b00, 2'b11, 2'b01, 2'b10, 2'b00, 6'b0};
  localparam logic [15:0] TO_E2    = {2'b10, 2'b11, 12'b0};
  localparam logic [15:0] AFTER_RST = {2'b01, 2'b00, 12'b0};

  // Directed plan followed by biased random walks on both lanes.
  initial begin
    reset = 1'b0;
    a = '0;
    b = '0;
    for (int l = 0; l < LANES; l++) genPos[l] = 0;
    modelReset();
    doReset();
    checkField("rst_empty", 32'(dutEmptyA), 32'd1);

    playSeq(0, ENTRY, 5);
    settle();
    checkField("plan_entry_count", 32'(dutCountA), 32'd1);

    playSeq(1, EXIT, 5);
    settle();
    checkField("plan_exit_count", 32'(dutCountA), 32'd0);

    playSeq(0, ABORT, 4);
    playSeq(0, REVERSAL, 6);
    settle();
    checkField("plan_abort_count", 32'(dutCountA), 32'd0);

    playBoth(ENTRY, ENTRY, 5);
    playBoth(ENTRY, ENTRY, 5);
    playSeq(0, ENTRY, 5);
    settle();
    playBoth(ENTRY, EXIT, 5);
    settle();
    checkField("plan_cancel_count", 32'(dutCountA), 32'd5);
    playBoth(ENTRY, ENTRY, 5);
    settle();
    checkField("plan_dual_entry_count", 32'(dutCountA), 32'd7);

    doReset();
    for (int i = 0; i < 4; i++) playSeq(0, ENTRY, 5);
    settle();
    checkField("plan_sat_countB", 32'(dutCountB), 32'd3);
    checkField("plan_sat_ovfB", 32'(dutOvfB), 32'd1);
    playSeq(1, EXIT, 5);
    settle();
    checkField("plan_sat_exit_countB", 32'(dutCountB), 32'd2);

    playSeq(0, JUMP, 5);
    playSeq(0, ENTRY, 5);
    settle();

    playSeq(0, TO_E2, 2);
    doReset();
    playSeq(0, AFTER_RST, 2);
    settle();

    randomPhase(400, 1, 1);
    randomPhase(400, -1, -1);
    randomPhase(200, 1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
